// File: rtl/ldst_agu_unit_pkg.sv
// Shared definitions for the load/store address-generation unit:
// state encoding, datapath width and default timeout.
package ldst_agu_unit_pkg;

    localparam int LDST_DATA_W  = 16;
    localparam int LDST_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } ldst_state_e;

endpackage

// File: rtl/ldst_agu_unit_if.sv
// Data-memory request/acknowledge bus between the AGU (master) and memory (slave).
interface ldst_agu_unit_if
    import ldst_agu_unit_pkg::*;
#(
    parameter int DATA_W = LDST_DATA_W
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/ldst_agu_unit_timeout_ctr.sv
// Request-cycle counter; tc flags the last cycle a request may wait for an ack.
module ldst_timeout_ctr #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/ldst_agu_unit.sv
// Load/store stage: forms Base+Imm_Ex, runs one req/ack memory access,
// stalls the CPU meanwhile and aborts if memory never acknowledges.
//
// state   | meaning
// IDLE    | waiting for start; address and store data latched on acceptance
// REQ     | mem_req held with stable outputs until ack or timeout
// DONE    | one-cycle Done (and Err on abort) pulse; start ignored
module ldst_agu_unit
    import ldst_agu_unit_pkg::*;
#(
    parameter int DATA_W  = LDST_DATA_W,
    parameter int TIMEOUT = LDST_TIMEOUT,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              is_store,
    input  logic [DATA_W-1:0] Base,
    input  logic [DATA_W-1:0] Imm_Ex,
    input  logic [DATA_W-1:0] StoreData,
    ldst_agu_unit_if.master   mem,
    output logic              Stall,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] LoadData
);
    ldst_state_e       state;
    logic              tc;
    logic              ctr_clr;
    logic              ctr_en;
    logic [DATA_W-1:0] eff_addr;

    // Modular add; address wrap is intentional, no carry is kept.
    assign eff_addr = Base + Imm_Ex;

    assign ctr_clr = (state == ST_IDLE) && start;
    assign ctr_en  = (state == ST_REQ) && !mem.mem_ack;

    ldst_timeout_ctr #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ctr_clr),
        .en    (ctr_en),
        .tc    (tc)
    );

    assign Stall = ((state == ST_IDLE) && start) || (state == ST_REQ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            Done          <= 1'b0;
            Err           <= 1'b0;
            LoadData      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    Done <= 1'b0;
                    Err  <= 1'b0;
                    if (start) begin
                        state         <= ST_REQ;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= is_store;
                        mem.mem_addr  <= eff_addr;
                        mem.mem_wdata <= StoreData;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (mem.mem_ack) begin
                        state       <= ST_DONE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        Done        <= 1'b1;
                        Err         <= 1'b0;
                        if (!mem.mem_we) begin
                            LoadData <= mem.mem_rdata;
                        end
                    end else if (tc) begin
                        state       <= ST_DONE;
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        Done        <= 1'b1;
                        Err         <= 1'b1;
                        LoadData    <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Done  <= 1'b0;
                    Err   <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    mem.mem_req <= 1'b0;
                    mem.mem_we  <= 1'b0;
                    Done        <= 1'b0;
                    Err         <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ldst_agu_unit.sv
// Self-checking bench for ldst_agu_unit (TIMEOUT=4) with an expected-result queue.
module tb_ldst_agu_unit;
    localparam int TO = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [15:0] Base;
    logic [15:0] Imm_Ex;
    logic [15:0] StoreData;
    logic        Stall;
    logic        Done;
    logic        Err;
    logic [15:0] LoadData;

    ldst_agu_unit_if #(.DATA_W(16)) mem_bus ();

    ldst_agu_unit #(
        .DATA_W  (16),
        .TIMEOUT (TO),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_store  (is_store),
        .Base      (Base),
        .Imm_Ex    (Imm_Ex),
        .StoreData (StoreData),
        .mem       (mem_bus.master),
        .Stall     (Stall),
        .Done      (Done),
        .Err       (Err),
        .LoadData  (LoadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] load;
        logic        err;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model_load;
    int          total;
    int          bad;

    int          obs_done_cyc;
    int          obs_done_cnt;
    int          obs_req_cnt;
    int          obs_first_req;
    logic [15:0] obs_addr;
    logic [15:0] obs_wdata;
    logic [15:0] obs_load;
    logic        obs_we;
    logic        obs_err;
    logic        obs_stable;
    logic        stall_log [0:31];

    // Runs one access: cycle 0 presents start, memory acks in cycle ack_at
    // (negative or out of range = never). Other inputs are scrambled after cycle 0.
    task automatic drive_access(input logic [15:0] b, input logic [15:0] im,
                                input logic [15:0] sd, input logic st,
                                input int ack_at, input logic [15:0] rd,
                                input int start_len, input int ncyc);
        exp_t e;
        bit   ok;
        ok         = (ack_at >= 1) && (ack_at <= TO);
        e.addr     = b + im;
        e.we       = st;
        e.wdata    = sd;
        e.err      = !ok;
        e.done_cyc = ok ? ack_at + 1 : TO + 1;
        e.load     = ok ? (st ? model_load : rd) : 16'h0000;
        model_load = e.load;
        sb.push_back(e);

        obs_done_cyc  = -1;
        obs_done_cnt  = 0;
        obs_req_cnt   = 0;
        obs_first_req = -1;
        obs_stable    = 1'b1;
        obs_addr      = 16'hxxxx;
        obs_wdata     = 16'hxxxx;
        obs_we        = 1'bx;
        obs_load      = 16'hxxxx;
        obs_err       = 1'bx;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            start             = (c < start_len);
            is_store          = (c == 0) ? st : ~st;
            Base              = (c == 0) ? b  : 16'($urandom);
            Imm_Ex            = (c == 0) ? im : 16'($urandom);
            StoreData         = (c == 0) ? sd : 16'($urandom);
            mem_bus.mem_ack   = (c == ack_at);
            mem_bus.mem_rdata = (c == ack_at) ? rd : 16'($urandom);
            @(negedge clk);
            if (c < 32) stall_log[c] = Stall;
            if (mem_bus.mem_req) begin
                obs_req_cnt++;
                if (obs_first_req < 0) begin
                    obs_first_req = c;
                    obs_addr      = mem_bus.mem_addr;
                    obs_we        = mem_bus.mem_we;
                    obs_wdata     = mem_bus.mem_wdata;
                end else if (mem_bus.mem_addr !== obs_addr || mem_bus.mem_we !== obs_we ||
                             mem_bus.mem_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
            end
            if (Done) begin
                obs_done_cnt++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = c;
                    obs_load     = LoadData;
                    obs_err      = Err;
                end
            end
        end
        start           = 1'b0;
        mem_bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({mem_bus.mem_req, mem_bus.mem_we, Done, Err, Stall} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {mem_bus.mem_req, mem_bus.mem_we, Done, Err, Stall});
        end
        total++;
        if ({mem_bus.mem_addr, mem_bus.mem_wdata, LoadData} !== 48'h0) begin
            bad++;
            $display("FAIL reset_data got=%h exp=0", {mem_bus.mem_addr, mem_bus.mem_wdata, LoadData});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_load = 16'h0000;
    endtask

    task automatic test_load_neg_offset();
        exp_t e;
        drive_access(16'h0010, 16'hFFFC, 16'h5555, 1'b0, 2, 16'hBEEF, 1, 6);
        e = sb.pop_front();
        total++;
        if (obs_addr !== e.addr || obs_addr !== 16'h000C) begin
            bad++; $display("FAIL load_addr got=%h exp=%h", obs_addr, e.addr);
        end
        total++;
        if (obs_we !== 1'b0 || obs_first_req !== 1) begin
            bad++; $display("FAIL load_req got_we=%b first=%0d exp_we=0 first=1", obs_we, obs_first_req);
        end
        total++;
        if (obs_done_cyc !== e.done_cyc) begin
            bad++; $display("FAIL load_done_cyc got=%0d exp=%0d", obs_done_cyc, e.done_cyc);
        end
        total++;
        if (obs_load !== e.load || obs_err !== e.err) begin
            bad++; $display("FAIL load_data got=%h err=%b exp=%h err=%b", obs_load, obs_err, e.load, e.err);
        end
        total++;
        if ({stall_log[0], stall_log[1], stall_log[2], stall_log[3]} !== 4'b1110) begin
            bad++; $display("FAIL load_stall got=%b exp=1110",
                            {stall_log[0], stall_log[1], stall_log[2], stall_log[3]});
        end
        total++;
        if (obs_stable !== 1'b1 || obs_req_cnt !== 2) begin
            bad++; $display("FAIL load_req_hold stable=%b cnt=%0d exp stable=1 cnt=2", obs_stable, obs_req_cnt);
        end
    endtask

    task automatic test_store_wrap();
        exp_t e;
        drive_access(16'hFFFE, 16'h0003, 16'h1234, 1'b1, 1, 16'h9999, 1, 5);
        e = sb.pop_front();
        total++;
        if (obs_addr !== e.addr || obs_we !== 1'b1 || obs_wdata !== e.wdata) begin
            bad++; $display("FAIL store_bus got=%h/%b/%h exp=%h/1/%h", obs_addr, obs_we, obs_wdata, e.addr, e.wdata);
        end
        total++;
        if (obs_done_cyc !== e.done_cyc || obs_load !== e.load || obs_err !== 1'b0) begin
            bad++; $display("FAIL store_done got cyc=%0d load=%h err=%b exp cyc=%0d load=%h err=0",
                            obs_done_cyc, obs_load, obs_err, e.done_cyc, e.load);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        drive_access(16'h0100, 16'h0002, 16'h0000, 1'b0, -1, 16'h0000, 1, 8);
        e = sb.pop_front();
        total++;
        if (obs_req_cnt !== TO || obs_done_cyc !== e.done_cyc) begin
            bad++; $display("FAIL timeout_len got req=%0d done=%0d exp req=%0d done=%0d",
                            obs_req_cnt, obs_done_cyc, TO, e.done_cyc);
        end
        total++;
        if (obs_err !== 1'b1 || obs_load !== e.load) begin
            bad++; $display("FAIL timeout_err got err=%b load=%h exp err=1 load=%h", obs_err, obs_load, e.load);
        end
        total++;
        if (stall_log[TO] !== 1'b1 || stall_log[TO+1] !== 1'b0) begin
            bad++; $display("FAIL timeout_stall got=%b%b exp=10", stall_log[TO], stall_log[TO+1]);
        end
    endtask

    task automatic test_ack_on_tc();
        exp_t e;
        drive_access(16'h0200, 16'h0001, 16'h0000, 1'b0, TO, 16'h00AA, 1, 8);
        e = sb.pop_front();
        total++;
        if (obs_err !== 1'b0 || obs_load !== 16'h00AA || obs_load !== e.load) begin
            bad++; $display("FAIL ack_on_tc got err=%b load=%h exp err=0 load=%h", obs_err, obs_load, e.load);
        end
        total++;
        if (obs_done_cyc !== e.done_cyc || obs_done_cnt !== 1) begin
            bad++; $display("FAIL ack_on_tc_done got cyc=%0d cnt=%0d exp cyc=%0d cnt=1",
                            obs_done_cyc, obs_done_cnt, e.done_cyc);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_access(16'h0300, 16'h0004, 16'h0000, 1'b0, 1, 16'h7777, 3, 5);
        e = sb.pop_front();
        total++;
        if (obs_done_cnt !== 1 || obs_done_cyc !== e.done_cyc || obs_req_cnt !== 1) begin
            bad++; $display("FAIL b2b_first got dones=%0d cyc=%0d reqs=%0d exp dones=1 cyc=%0d reqs=1",
                            obs_done_cnt, obs_done_cyc, obs_req_cnt, e.done_cyc);
        end
        total++;
        if (stall_log[3] !== 1'b0 || stall_log[4] !== 1'b0) begin
            bad++; $display("FAIL b2b_gap got stall=%b%b exp=00", stall_log[3], stall_log[4]);
        end
        drive_access(16'h0020, 16'h0007, 16'h0000, 1'b0, 1, 16'h4321, 1, 4);
        e = sb.pop_front();
        total++;
        if (obs_addr !== e.addr || obs_addr !== 16'h0027 || obs_first_req !== 1) begin
            bad++; $display("FAIL b2b_second got addr=%h first=%0d exp addr=%h first=1",
                            obs_addr, obs_first_req, e.addr);
        end
        total++;
        if (obs_load !== e.load) begin
            bad++; $display("FAIL b2b_second_load got=%h exp=%h", obs_load, e.load);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   dones;
        dones = 0;
        @(posedge clk);
        #1;
        start    = 1'b1;
        is_store = 1'b0;
        Base     = 16'h0400;
        Imm_Ex   = 16'h0000;
        @(posedge clk);
        #1;
        total++;
        if (mem_bus.mem_req !== 1'b1) begin
            bad++; $display("FAIL rstmid_in_req got=%b exp=1", mem_bus.mem_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_bus.mem_req !== 1'b0 || LoadData !== 16'h0000) begin
            bad++; $display("FAIL rstmid_async got req=%b load=%h exp req=0 load=0000", mem_bus.mem_req, LoadData);
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (Done) dones++;
        end
        rst_n      = 1'b1;
        model_load = 16'h0000;
        repeat (2) begin
            @(negedge clk);
            if (Done || mem_bus.mem_req) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++; $display("FAIL rstmid_no_done got=%0d exp=0", dones);
        end
        drive_access(16'h0500, 16'h0005, 16'h0000, 1'b0, 2, 16'hC0DE, 1, 5);
        e = sb.pop_front();
        total++;
        if (obs_addr !== e.addr || obs_done_cyc !== e.done_cyc || obs_load !== e.load) begin
            bad++; $display("FAIL rstmid_recover got addr=%h cyc=%0d load=%h exp addr=%h cyc=%0d load=%h",
                            obs_addr, obs_done_cyc, obs_load, e.addr, e.done_cyc, e.load);
        end
    endtask

    initial begin
        total             = 0;
        bad               = 0;
        model_load        = 16'h0000;
        start             = 1'b0;
        is_store          = 1'b0;
        Base              = 16'h0000;
        Imm_Ex            = 16'h0000;
        StoreData         = 16'h0000;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        test_reset();
        test_load_neg_offset();
        test_store_wrap();
        test_timeout();
        test_ack_on_tc();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ldst_agu_unit.md
Name: ldst_agu_unit

Overview:
Load/store address-generation and memory-handshake stage. It sits directly downstream of the memory-offset sign extender. It consumes the 16-bit sign-extended offset Imm_Ex, adds it to the base register value, and performs one data-memory transaction over a req/ack interface. While the transaction is in flight it stalls the CPU, then returns load data, with a timeout guard for a memory that never acknowledges.

Parameters:
DATA_W, 16, data and address width (fixed at 16 for this CPU; the parameter exists for documentation only)
TIMEOUT, 16, maximum REQ cycles without mem_ack before the access is aborted (legal range 2..255)
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  single system clock; everything is rising-edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  instruction is a load or store; held high by the CPU while Stall is high.
is_store  in  1  1 = store, 0 = load; sampled with start.
Base  in  16  base register value.
Imm_Ex  in  16  sign-extended offset from the sign extender.
StoreData  in  16  store data.
mem_req  out  1  memory request.
mem_we  out  1  write enable, valid while mem_req is high.
mem_addr  out  16  word address.
mem_wdata  out  16  write data.
mem_ack  in  1  memory completion, one cycle.
mem_rdata  in  16  read data, valid with mem_ack.
Stall  out  1  freeze PC and register file.
Done  out  1  one-cycle completion pulse.
Err  out  1  one-cycle timeout pulse, coincident with Done.
LoadData  out  16  registered load result.

Behaviour:
- Reset (asynchronous assert, synchronous release): state is IDLE. mem_req, mem_we, Done and Err are 0. mem_addr, mem_wdata and LoadData are 0x0000. The timeout counter is 0.
- Address arithmetic: mem_addr = (Base + Imm_Ex) mod 2^16, with no carry or overflow flag. It is registered on acceptance and held constant through REQ.
- States: IDLE, REQ, DONE.
- IDLE:
  - start=1 causes transition to REQ at the next edge.
  - At that edge, latch mem_addr, mem_we=is_store, and mem_wdata=StoreData.
  - Clear the counter.
- REQ:
  - mem_req=1 and all request outputs are stable.
  - mem_ack=1 causes transition to DONE. For a load, LoadData <= mem_rdata. For a store, LoadData is unchanged.
  - mem_ack=0 increments the counter. If the counter equals TIMEOUT-1 and there is no ack, go to DONE with Err flagged and LoadData <= 0x0000.
  - If ack and the timeout condition occur in the same cycle, ack wins and Err=0.
- DONE:
  - Done=1 for exactly one cycle; Err=1 in the same cycle only if the access aborted.
  - mem_req=0 and mem_we=0.
  - start is ignored here because it still belongs to the retiring instruction.
  - Always returns to IDLE.
- Stall (combinational) = (state==IDLE && start) || state==REQ; it is 0 in DONE.
- Latency: with the start cycle as cycle 0, mem_req is first high in cycle 1. An ack in cycle k gives Done in cycle k+1, and minimum total latency is 3 cycles (Done in cycle 2 if ack arrives in cycle 1).
- Back-to-back accesses: the next start is accepted in the IDLE cycle after DONE, so there is at least one idle cycle between requests.
- mem_ack outside REQ is ignored.
- Input changes during REQ (Base, Imm_Ex, StoreData, is_store) have no effect.
- Reset mid-transaction: mem_req drops immediately (asynchronously), no Done is issued, and LoadData returns to 0.

Decomposition:
- A shared package holds the state encoding constants (IDLE=2'd0, REQ=2'd1, DONE=2'd2), DATA_W, and the default TIMEOUT.
- One natural sub-module, ldst_timeout_ctr: a counter with clear/enable inputs and a terminal-count output (count==TIMEOUT-1).
- The FSM, address adder and data registers stay in the top level.

Test Plan:
1. Reset, then a load: Base=0x0010, Imm_Ex=0xFFFC (offset -4), memory acks in cycle 2 with 0xBEEF → mem_addr=0x000C, mem_we=0, Stall=1 in cycles 0–2, Done in cycle 3, LoadData=0xBEEF, Err=0.
2. Store with address wrap: Base=0xFFFE, Imm_Ex=0x0003, StoreData=0x1234, immediate ack → mem_addr=0x0001, mem_we=1, mem_wdata=0x1234, Done in cycle 2, LoadData unchanged.
3. Timeout with TIMEOUT=4: no ack → mem_req high for 4 cycles, then Done=1, Err=1, LoadData=0x0000, Stall low in the DONE cycle.
4. Ack exactly on the terminal-count cycle with mem_rdata=0x00AA → Err=0 and LoadData=0x00AA.
5. start held high through DONE, followed by a second load: Base=0x0020, Imm_Ex=0x0007 → exactly one Done for the first access, an IDLE gap, then a new request at mem_addr=0x0027.
6. rst_n asserted in the middle of REQ → mem_req=0 immediately with no Done pulse; after release the unit is in IDLE and accepts a new start normally.
